// File: rtl/aes_round_pipe.sv
// aes_round_pipe: pipelined AES-128 encryption round.
//   SubBytes -> ShiftRows -> [MixColumns, skipped when last=1] -> AddRoundKey.
//   PIPE_STAGES selects 1..3 register stages; key/last/tag travel with the data.
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready      input handshake (in_ready is combinational from out_ready)
//   in_state, in_key         128-bit state and round key, column-major bytes
//                            ([127:120]=s[0][0], [119:112]=s[1][0], ..., [7:0]=s[3][3])
//   in_last, in_tag          final-round flag and sideband tag, sampled on acceptance
//   out_valid / out_ready    output handshake
//   out_state, out_last, out_tag  round result and delayed sideband, from last-stage registers
module aes_round_pipe #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_state,
    input  logic [127:0]     in_key,
    input  logic             in_last,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_state,
    output logic             out_last,
    output logic [TAG_W-1:0] out_tag
);
    localparam int unsigned NS = PIPE_STAGES;
    localparam int unsigned SW = 128;

    // Elaboration-time parameter checks
    if (DATA_WIDTH != 8) begin : g_bad_width
        $error("aes_round_pipe: DATA_WIDTH must be 8");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_stages
        $error("aes_round_pipe: PIPE_STAGES must be 1..3");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("aes_round_pipe: TAG_W must be >= 1");
    end

    // FIPS-197 forward S-box, entry 0 first
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [SW-1:0] sub_bytes(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[s[8*i +: 8]];
        return r;
    endfunction

    // ShiftRows followed by MixColumns unless this is the final round
    function automatic logic [SW-1:0] mix_shift(input logic [SW-1:0] s, input logic last);
        logic [SW-1:0] t;
        logic [SW-1:0] m;
        logic [7:0]    a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[8*(15-4*c-r) +: 8] = s[8*(15-4*((c+r)%4)-r) +: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = t[8*(15-4*c) +: 8];
            a1 = t[8*(14-4*c) +: 8];
            a2 = t[8*(13-4*c) +: 8];
            a3 = t[8*(12-4*c) +: 8];
            m[8*(15-4*c) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            m[8*(14-4*c) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            m[8*(13-4*c) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            m[8*(12-4*c) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return last ? t : m;
    endfunction

    // Logic placed in front of register stage k for the chosen depth
    function automatic logic [SW-1:0] stage_fn(input int k, input logic [SW-1:0] x,
                                               input logic [SW-1:0] key, input logic last);
        logic [SW-1:0] r;
        if (NS == 1) begin
            r = mix_shift(sub_bytes(x), last) ^ key;
        end else if (NS == 2) begin
            r = (k == 0) ? sub_bytes(x) : (mix_shift(x, last) ^ key);
        end else begin
            case (k)
                0:       r = sub_bytes(x);
                1:       r = mix_shift(x, last);
                default: r = x ^ key;
            endcase
        end
        return r;
    endfunction

    // Stage registers
    logic [NS-1:0]    v_q, v_d;
    logic [NS-1:0]    l_q, l_d;
    logic [SW-1:0]    s_q [NS];
    logic [SW-1:0]    s_d [NS];
    logic [SW-1:0]    k_q [NS];
    logic [SW-1:0]    k_d [NS];
    logic [TAG_W-1:0] t_q [NS];
    logic [TAG_W-1:0] t_d [NS];

    // Per-stage source (index 0 is the input port) and ready chain (index NS is out_ready)
    logic             src_v [NS+1];
    logic             src_l [NS+1];
    logic [SW-1:0]    src_s [NS+1];
    logic [SW-1:0]    src_k [NS+1];
    logic [TAG_W-1:0] src_t [NS+1];
    logic             rdy   [NS+1];

    // Source selection and backward ready chain: a stage can load if empty or draining
    always_comb begin
        src_v[0] = in_valid;
        src_l[0] = in_last;
        src_s[0] = in_state;
        src_k[0] = in_key;
        src_t[0] = in_tag;
        for (int k = 0; k < int'(NS); k++) begin
            src_v[k+1] = v_q[k];
            src_l[k+1] = l_q[k];
            src_s[k+1] = s_q[k];
            src_k[k+1] = k_q[k];
            src_t[k+1] = t_q[k];
        end
        rdy[NS] = out_ready;
        for (int k = int'(NS) - 1; k >= 0; k--) begin
            rdy[k] = !v_q[k] || rdy[k+1];
        end
    end

    // Next-state: load valid (bubbles included) when ready, payload only with a valid source
    always_comb begin
        for (int k = 0; k < int'(NS); k++) begin
            v_d[k] = v_q[k];
            l_d[k] = l_q[k];
            s_d[k] = s_q[k];
            k_d[k] = k_q[k];
            t_d[k] = t_q[k];
            if (rdy[k]) begin
                v_d[k] = src_v[k];
                if (src_v[k]) begin
                    s_d[k] = stage_fn(k, src_s[k], src_k[k], src_l[k]);
                    k_d[k] = src_k[k];
                    l_d[k] = src_l[k];
                    t_d[k] = src_t[k];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            l_q <= '0;
            for (int k = 0; k < int'(NS); k++) begin
                s_q[k] <= '0;
                k_q[k] <= '0;
                t_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            l_q <= l_d;
            for (int k = 0; k < int'(NS); k++) begin
                s_q[k] <= s_d[k];
                k_q[k] <= k_d[k];
                t_q[k] <= t_d[k];
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[NS-1];
    assign out_last  = l_q[NS-1];
    assign out_state = s_q[NS-1];
    assign out_tag   = t_q[NS-1];

endmodule

// File: tb/tb_aes_round_pipe.sv
// tb_aes_round_pipe: runs every scenario against PIPE_STAGES = 1, 2 and 3 instances in turn,
// checking results against an AES round model built from GF(2^8) arithmetic.
module tb_aes_round_pipe;
    localparam int NI = 3;

    localparam logic [127:0] V1_S = 128'heb40f21e592e38848ba113e71bc342d2;
    localparam logic [127:0] V1_K = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] V1_E = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] V2_S = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] V2_K = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] V2_E = 128'ha49c7ff2689f352b6b5bea43026a5049;

    typedef struct {
        logic [127:0] s;
        logic         l;
        logic [3:0]   t;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_state, in_key;
    logic         in_last;
    logic [3:0]   in_tag;
    logic         in_valid_a  [NI];
    logic         in_ready_a  [NI];
    logic         out_valid_a [NI];
    logic         out_ready_a [NI];
    logic [127:0] out_state_a [NI];
    logic         out_last_a  [NI];
    logic [3:0]   out_tag_a   [NI];

    int n_checks;
    int n_pass;
    int sel;
    logic [7:0] sb_tab [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        aes_round_pipe #(.DATA_WIDTH(8), .PIPE_STAGES(g + 1), .TAG_W(4)) u_dut (
            .clk(clk), .rst(rst),
            .in_valid(in_valid_a[g]), .in_ready(in_ready_a[g]),
            .in_state(in_state), .in_key(in_key), .in_last(in_last), .in_tag(in_tag),
            .out_valid(out_valid_a[g]), .out_ready(out_ready_a[g]),
            .out_state(out_state_a[g]), .out_last(out_last_a[g]), .out_tag(out_tag_a[g])
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // S-box from multiplicative inverse plus affine transform
    task automatic init_sbox();
        logic [7:0] xv, inv, bv;
        for (int x = 0; x < 256; x++) begin
            xv  = 8'(x);
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                bv = 8'(b);
                if (xv != 8'h00 && gmul(xv, bv) == 8'h01) inv = bv;
            end
            sb_tab[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   a [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   m [4][4];
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) a[r][c] = sb_tab[s[127-8*(4*c+r) -: 8]];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r][c] = a[r][(c + r) % 4];
        for (int c = 0; c < 4; c++) begin
            m[0][c] = gmul(8'h02, t[0][c]) ^ gmul(8'h03, t[1][c]) ^ t[2][c] ^ t[3][c];
            m[1][c] = t[0][c] ^ gmul(8'h02, t[1][c]) ^ gmul(8'h03, t[2][c]) ^ t[3][c];
            m[2][c] = t[0][c] ^ t[1][c] ^ gmul(8'h02, t[2][c]) ^ gmul(8'h03, t[3][c]);
            m[3][c] = gmul(8'h03, t[0][c]) ^ t[1][c] ^ t[2][c] ^ gmul(8'h02, t[3][c]);
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = (last ? t[r][c] : m[r][c]) ^ k[127-8*(4*c+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set_idle();
        for (int i = 0; i < NI; i++) begin
            in_valid_a[i]  = 1'b0;
            out_ready_a[i] = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid_a[sel], out_last_a[sel], out_tag_a[sel]} !== 6'b0 || out_state_a[sel] !== 128'h0)
            $display("FAIL reset_outputs p=%0d got v=%b l=%b t=%h s=%h want all zero", sel + 1,
                     out_valid_a[sel], out_last_a[sel], out_tag_a[sel], out_state_a[sel]);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        step();
        n_checks++;
        if (in_ready_a[sel] !== 1'b1 || out_valid_a[sel] !== 1'b0)
            $display("FAIL reset_idle p=%0d got in_ready=%b out_valid=%b want 1/0", sel + 1,
                     in_ready_a[sel], out_valid_a[sel]);
        else n_pass++;
    endtask

    task automatic test_known_round(input string name, input logic [127:0] s, input logic [127:0] k,
                                    input logic l, input logic [127:0] e);
        int cyc;
        out_ready_a[sel] = 1'b1;
        in_state = s; in_key = k; in_last = l; in_tag = 4'ha;
        in_valid_a[sel] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready_a[sel] !== 1'b1)
            $display("FAIL %s_in_ready p=%0d got %b want 1", name, sel + 1, in_ready_a[sel]);
        else n_pass++;
        step();
        // scramble inputs so a late re-read of key/last would show up
        in_valid_a[sel] = 1'b0;
        in_state = ~s; in_key = ~k; in_last = ~l; in_tag = 4'h5;
        cyc = 1;
        while (out_valid_a[sel] !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        n_checks++;
        if (cyc != sel + 1)
            $display("FAIL %s_latency p=%0d got %0d want %0d", name, sel + 1, cyc, sel + 1);
        else n_pass++;
        n_checks++;
        if (out_state_a[sel] !== e || out_last_a[sel] !== l || out_tag_a[sel] !== 4'ha)
            $display("FAIL %s_result p=%0d got s=%h l=%b t=%h want s=%h l=%b t=a", name, sel + 1,
                     out_state_a[sel], out_last_a[sel], out_tag_a[sel], e, l);
        else n_pass++;
        step();
        n_checks++;
        if (out_valid_a[sel] !== 1'b0)
            $display("FAIL %s_drain p=%0d got out_valid=%b want 0", name, sel + 1, out_valid_a[sel]);
        else n_pass++;
    endtask

    task automatic test_streaming();
        logic [127:0] vs [4], vk [4], ve [4];
        logic         vl [4];
        int acc = 0;
        int outc = 0;
        for (int j = 0; j < 4; j++) begin
            vs[j] = (j % 2 == 0) ? V1_S : V2_S;
            vk[j] = (j % 2 == 0) ? V1_K : V2_K;
            ve[j] = (j % 2 == 0) ? V1_E : V2_E;
            vl[j] = (j % 2 == 0);
        end
        out_ready_a[sel] = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            in_valid_a[sel] = (acc < 4);
            if (acc < 4) begin
                in_state = vs[acc]; in_key = vk[acc]; in_last = vl[acc]; in_tag = 4'(acc);
            end
            @(negedge clk);
            if (acc < 4) begin
                n_checks++;
                if (in_ready_a[sel] !== 1'b1)
                    $display("FAIL stream_in_ready p=%0d item=%0d got %b want 1", sel + 1, acc, in_ready_a[sel]);
                else n_pass++;
                if (in_ready_a[sel] === 1'b1) acc++;
            end
            if (out_valid_a[sel] === 1'b1) begin
                n_checks++;
                if (outc >= 4)
                    $display("FAIL stream_extra p=%0d cycle=%0d got extra output want none", sel + 1, cyc);
                else if (out_state_a[sel] !== ve[outc] || out_last_a[sel] !== vl[outc] ||
                         out_tag_a[sel] !== 4'(outc) || cyc != sel + 1 + outc)
                    $display("FAIL stream_out p=%0d idx=%0d got s=%h l=%b t=%h cyc=%0d want s=%h l=%b t=%0d cyc=%0d",
                             sel + 1, outc, out_state_a[sel], out_last_a[sel], out_tag_a[sel], cyc,
                             ve[outc], vl[outc], outc, sel + 1 + outc);
                else n_pass++;
                outc++;
            end
            step();
        end
        in_valid_a[sel] = 1'b0;
        n_checks++;
        if (outc != 4)
            $display("FAIL stream_count p=%0d got %0d want 4", sel + 1, outc);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [127:0] is [5], ik [5];
        logic         il [5];
        exp_t         q [$];
        exp_t         snap, got;
        int  acc = 0;
        int  delivered = 0;
        bit  held = 0;
        for (int j = 0; j < 5; j++) begin
            is[j] = rand128(); ik[j] = rand128(); il[j] = 1'($urandom_range(1));
        end
        out_ready_a[sel] = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            in_valid_a[sel] = (acc < 5);
            in_state = is[acc % 5]; in_key = ik[acc % 5]; in_last = il[acc % 5]; in_tag = 4'(acc + 8);
            @(negedge clk);
            got = '{out_state_a[sel], out_last_a[sel], out_tag_a[sel]};
            if (held) begin
                n_checks++;
                if (out_valid_a[sel] !== 1'b1 || got != snap)
                    $display("FAIL bp_stable p=%0d cyc=%0d got v=%b s=%h want v=1 s=%h", sel + 1, cyc,
                             out_valid_a[sel], got.s, snap.s);
                else n_pass++;
            end else if (out_valid_a[sel] === 1'b1) begin
                snap = got;
                held = 1;
            end
            if (in_valid_a[sel] && in_ready_a[sel] === 1'b1) begin
                q.push_back('{ref_round(is[acc], ik[acc], il[acc]), il[acc], 4'(acc + 8)});
                acc++;
            end
            step();
        end
        n_checks++;
        if (acc != sel + 1)
            $display("FAIL bp_accepted p=%0d got %0d want %0d", sel + 1, acc, sel + 1);
        else n_pass++;
        n_checks++;
        if (in_ready_a[sel] !== 1'b0 || out_valid_a[sel] !== 1'b1)
            $display("FAIL bp_full p=%0d got in_ready=%b out_valid=%b want 0/1", sel + 1,
                     in_ready_a[sel], out_valid_a[sel]);
        else n_pass++;
        out_ready_a[sel] = 1'b1;
        for (int cyc = 0; cyc < 40 && delivered < 5; cyc++) begin
            in_valid_a[sel] = (acc < 5);
            in_state = is[acc % 5]; in_key = ik[acc % 5]; in_last = il[acc % 5]; in_tag = 4'(acc + 8);
            @(negedge clk);
            if (in_valid_a[sel] && in_ready_a[sel] === 1'b1) begin
                q.push_back('{ref_round(is[acc], ik[acc], il[acc]), il[acc], 4'(acc + 8)});
                acc++;
            end
            if (out_valid_a[sel] === 1'b1) begin
                got = '{out_state_a[sel], out_last_a[sel], out_tag_a[sel]};
                n_checks++;
                if (q.size() == 0)
                    $display("FAIL bp_out p=%0d got unexpected output t=%h want none", sel + 1, got.t);
                else if (got != q[0])
                    $display("FAIL bp_out p=%0d idx=%0d got s=%h l=%b t=%h want s=%h l=%b t=%h", sel + 1,
                             delivered, got.s, got.l, got.t, q[0].s, q[0].l, q[0].t);
                else n_pass++;
                if (q.size() != 0) void'(q.pop_front());
                delivered++;
            end
            step();
        end
        in_valid_a[sel] = 1'b0;
        n_checks++;
        if (delivered != 5 || q.size() != 0)
            $display("FAIL bp_count p=%0d got delivered=%0d left=%0d want 5/0", sel + 1, delivered, q.size());
        else n_pass++;
    endtask

    task automatic test_random();
        exp_t         q [$];
        exp_t         got, prev;
        logic [127:0] cs, ck;
        logic         cl;
        logic [3:0]   ct;
        bit  presenting = 0;
        bit  prev_stall = 0;
        int  issued = 0;
        int  delivered = 0;
        for (int cyc = 0; cyc < 12000 && delivered < 1000; cyc++) begin
            if (!presenting && issued < 1000 && $urandom_range(1) == 1) begin
                cs = rand128(); ck = rand128(); cl = 1'($urandom_range(1)); ct = 4'($urandom);
                presenting = 1;
            end
            in_valid_a[sel] = presenting;
            in_state = cs; in_key = ck; in_last = cl; in_tag = ct;
            out_ready_a[sel] = 1'($urandom_range(1));
            @(negedge clk);
            got = '{out_state_a[sel], out_last_a[sel], out_tag_a[sel]};
            if (prev_stall) begin
                n_checks++;
                if (out_valid_a[sel] !== 1'b1 || got != prev)
                    $display("FAIL rand_stable p=%0d cyc=%0d got v=%b s=%h want v=1 s=%h", sel + 1, cyc,
                             out_valid_a[sel], got.s, prev.s);
                else n_pass++;
            end
            prev_stall = (out_valid_a[sel] === 1'b1) && !out_ready_a[sel];
            prev = got;
            if (presenting && in_ready_a[sel] === 1'b1) begin
                q.push_back('{ref_round(cs, ck, cl), cl, ct});
                presenting = 0;
                issued++;
            end
            if (out_valid_a[sel] === 1'b1 && out_ready_a[sel]) begin
                n_checks++;
                if (q.size() == 0)
                    $display("FAIL rand_out p=%0d got unexpected output t=%h want none", sel + 1, got.t);
                else if (got != q[0])
                    $display("FAIL rand_out p=%0d idx=%0d got s=%h l=%b t=%h want s=%h l=%b t=%h", sel + 1,
                             delivered, got.s, got.l, got.t, q[0].s, q[0].l, q[0].t);
                else n_pass++;
                if (q.size() != 0) void'(q.pop_front());
                delivered++;
            end
            step();
        end
        in_valid_a[sel] = 1'b0;
        out_ready_a[sel] = 1'b1;
        n_checks++;
        if (delivered != 1000 || q.size() != 0)
            $display("FAIL rand_count p=%0d got delivered=%0d left=%0d want 1000/0", sel + 1, delivered, q.size());
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        logic [127:0] s, k, e;
        logic         l;
        int need = (sel + 1 < 2) ? sel + 1 : 2;
        int acc = 0;
        int seen = 0;
        int cyc;
        out_ready_a[sel] = 1'b0;
        for (int c = 0; c < 10 && acc < need; c++) begin
            in_valid_a[sel] = 1'b1;
            in_state = rand128(); in_key = rand128(); in_last = 1'b0; in_tag = 4'(c);
            @(negedge clk);
            if (in_ready_a[sel] === 1'b1) acc++;
            step();
        end
        in_valid_a[sel] = 1'b0;
        cyc = 0;
        while (out_valid_a[sel] !== 1'b1 && cyc < 10) begin
            step();
            cyc++;
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid_a[sel], out_last_a[sel], out_tag_a[sel]} !== 6'b0 || out_state_a[sel] !== 128'h0)
            $display("FAIL midrst_outputs p=%0d got v=%b l=%b t=%h s=%h want all zero", sel + 1,
                     out_valid_a[sel], out_last_a[sel], out_tag_a[sel], out_state_a[sel]);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        step();
        s = rand128(); k = rand128(); l = 1'($urandom_range(1));
        e = ref_round(s, k, l);
        out_ready_a[sel] = 1'b1;
        in_valid_a[sel] = 1'b1;
        in_state = s; in_key = k; in_last = l; in_tag = 4'hc;
        @(negedge clk);
        n_checks++;
        if (in_ready_a[sel] !== 1'b1)
            $display("FAIL midrst_in_ready p=%0d got %b want 1", sel + 1, in_ready_a[sel]);
        else n_pass++;
        step();
        in_valid_a[sel] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (out_valid_a[sel] === 1'b1) begin
                seen++;
                n_checks++;
                if (out_state_a[sel] !== e || out_last_a[sel] !== l || out_tag_a[sel] !== 4'hc || c != sel + 1)
                    $display("FAIL midrst_out p=%0d got s=%h l=%b t=%h cyc=%0d want s=%h l=%b t=c cyc=%0d",
                             sel + 1, out_state_a[sel], out_last_a[sel], out_tag_a[sel], c, e, l, sel + 1);
                else n_pass++;
            end
            step();
        end
        n_checks++;
        if (seen != 1)
            $display("FAIL midrst_count p=%0d got %0d outputs want 1", sel + 1, seen);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        sel      = 0;
        rst      = 1'b1;
        in_state = '0; in_key = '0; in_last = 1'b0; in_tag = '0;
        set_idle();
        init_sbox();
        repeat (2) @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            sel = i;
            test_reset();
            test_known_round("final_round", V1_S, V1_K, 1'b1, V1_E);
            test_known_round("full_round", V2_S, V2_K, 1'b0, V2_E);
            test_streaming();
            test_backpressure();
            test_random();
            test_reset_midstream();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
